mp_add_seq: RTL and testbench



---
 rtl/mp_add_pkg.sv | 11 +
 rtl/adder_carry_para.sv | 14 +
 rtl/mp_add_seq.sv | 160 ++++++++++++++++
 tb/tb_mp_add_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision adder sequencer.
// Optional subtract mode is enabled by MP_ADD_SUB_EN in mp_add_seq.
package mp_add_pkg;

  typedef enum logic [1:0] {
    idle = 2'd0,
    op   = 2'd1,
    done = 2'd2
  } state_type;

endpackage

// File: rtl/adder_carry_para.sv
// N-bit ripple-carry adder slice shared across all slices of a wide operand.
module adder_carry_para #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one N-bit slice time-shared over K cycles, carry chained via a register.
// Define MP_ADD_SUB_EN to add the 'sub' port (a-b mod 2^W, cout=1 means no borrow).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
`ifdef MP_ADD_SUB_EN
  input  logic           sub,
`endif
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic           ready,
  output logic           done_tick,
  output logic [N*K-1:0] sum,
  output logic           cout
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] i_last = IW'(K - 1);

  state_type       state_r, state_next_s;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic            carry_r, cout_r;
  logic [IW-1:0]   i_r;
  logic            ready_r, done_r;
  logic            ready_next_s, done_next_s;
  logic [N-1:0]    slice_b_s, slice_sum_s;
  logic            slice_cout_s, carry_init_s;

`ifdef MP_ADD_SUB_EN
  logic            sub_r;

  // Subtract: invert the b slice and seed the carry with 1 (two's complement).
  always_comb begin
    carry_init_s = sub;
    if (sub_r) begin
      slice_b_s = ~b_r[N-1:0];
    end else begin
      slice_b_s = b_r[N-1:0];
    end
  end

  // Operation mode captured with the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_r <= 1'b0;
    end else if (state_r == idle && start) begin
      sub_r <= sub;
    end
  end
`else
  // Add-only b path.
  always_comb begin
    carry_init_s = 1'b0;
    slice_b_s    = b_r[N-1:0];
  end
`endif

  adder_carry_para #(.N(N)) u_slice (
    .a    (a_r[N-1:0]),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // State register plus registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= idle;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= ready_next_s;
      done_r  <= done_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      idle: begin
        if (start) begin
          state_next_s = op;
        end else begin
          state_next_s = idle;
        end
      end
      op: begin
        if (i_r == i_last) begin
          state_next_s = done;
        end else begin
          state_next_s = op;
        end
      end
      done:    state_next_s = idle;
      default: state_next_s = idle;
    endcase
  end

  // Output decode from the next state so ready/done_tick come straight from flops.
  always_comb begin
    ready_next_s = 1'b0;
    done_next_s  = 1'b0;
    case (state_next_s)
      idle:    ready_next_s = 1'b1;
      done:    done_next_s  = 1'b1;
      default: begin
        ready_next_s = 1'b0;
        done_next_s  = 1'b0;
      end
    endcase
  end

  // Datapath: operand load on accept, then one slice per op cycle shifted in from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      i_r     <= {IW{1'b0}};
    end else begin
      case (state_r)
        idle: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= carry_init_s;
            i_r     <= {IW{1'b0}};
          end
        end
        op: begin
          sum_r   <= {slice_sum_s, sum_r[W-1:N]};
          a_r     <= a_r >> N;
          b_r     <= b_r >> N;
          carry_r <= slice_cout_s;
          cout_r  <= slice_cout_s;
          i_r     <= i_r + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready     = ready_r;
  assign done_tick = done_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq (N=8, K=4); covers sub mode when MP_ADD_SUB_EN is defined.
module tb_mp_add_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        ready, done_tick, cout;
  logic [31:0] sum;
`ifdef MP_ADD_SUB_EN
  logic        sub;
`endif

  int checks   = 0;
  int failures = 0;

  mp_add_seq #(.N(8), .K(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef MP_ADD_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] es, input logic ec, input bit inject);
    int nd;
    nd    = 0;
    start = 1'b1;
    a     = av;
    b     = bv;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done_tick === 1'b1) nd++;
      if (c == 1) chk({tag, "_busy"}, ready, 1'b0);
      if (c <= 5) chk({tag, "_done_c"}, done_tick, (c == 5));
      if (c == 5) begin
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
      end
      if (c == 6) chk({tag, "_ready"}, ready, 1'b1);
      start = 1'b0;
      if (inject && c == 2) begin
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
      end
    end
    chk({tag, "_ndone"}, nd, 1);
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
`ifdef MP_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done_tick, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);

    run_op("add1", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
    run_op("ripple", 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("slice_carry", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    run_op("ignore", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b1);

    // Reset asserted during cycle 2 of an operation.
    start = 1'b1;
    a     = 32'h1234_5678;
    b     = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", ready, 1'b1);
    chk("abort_sum", sum, 32'h0);
    chk("abort_cout", cout, 1'b0);
    chk("abort_done", done_tick, 1'b0);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_tick !== 1'b0) nd++;
    end
    chk("abort_no_done", nd, 0);

    // Back-to-back with start held high; operands change right after the first accept.
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1111_1111;
    nd    = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done_tick === 1'b1) nd++;
      if (c <= 11) chk("b2b_done_c", done_tick, (c == 5 || c == 11));
      if (c == 5) begin
        chk("b2b_sum1", sum, 32'hEFBE_D000);
        chk("b2b_cout1", cout, 1'b0);
      end
      if (c == 6 || c == 12) chk("b2b_ready", ready, 1'b1);
      if (c == 7) chk("b2b_busy2", ready, 1'b0);
      if (c == 11) begin
        chk("b2b_sum2", sum, 32'h0000_0001);
        chk("b2b_cout2", cout, 1'b1);
        start = 1'b0;
      end
      if (c == 1) begin
        a = 32'h8000_0001;
        b = 32'h8000_0000;
      end
    end
    chk("b2b_ndone", nd, 2);

`ifdef MP_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_0m1", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_5m3", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0);
    sub = 1'b0;
    run_op("sub_off", 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
